// File: rtl/edge_window_counter.sv
// -----------------------------------------------------------------------------
// edge_window_counter
//
// Counts rising edges of a 1-bit event stream over fixed windows of WINDOW
// clock cycles. Each completed window total is offered on a one-entry
// valid/ready output register. If a new total arrives while the previous one
// is still unconsumed, the new total is discarded and the sticky drop flag
// is raised.
//
// Parameters:
//   WINDOW  cycles per counting window (>= 2)
//   CW      accumulator / count width
//
// Ports:
//   clk     in   single clock, rising edge
//   reset   in   synchronous, active-high reset
//   in      in   event stream (already synchronous to clk)
//   en      in   run enable; dropping it aborts the current window
//   ready   in   consumer accepts count
//   count   out  edge total of the last completed window
//   valid   out  count holds an unconsumed result
//   drop    out  sticky: a window result was discarded (cleared by reset)
//
// Configuration macro:
//   EDGE_WINDOW_SATURATE_EN  defined   -> accumulator saturates at 2^CW-1
//                            undefined -> accumulator wraps modulo 2^CW
// -----------------------------------------------------------------------------
module edge_window_counter #(
    parameter int WINDOW = 16,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in,
    input  logic          en,
    input  logic          ready,
    output logic [CW-1:0] count,
    output logic          valid,
    output logic          drop
);

    // Window position counter only needs to reach WINDOW-1.
    localparam int WCW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WINDOW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            in_q_reg;
    logic [WCW-1:0]  wcnt_reg;
    logic [WCW-1:0]  wcnt_next;
    logic [CW-1:0]   acc_reg;
    logic [CW-1:0]   acc_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            valid_reg;
    logic            valid_next;
    logic            drop_reg;
    logic            drop_next;

    logic            rise;
    logic [CW:0]     acc_sum;
    logic [CW-1:0]   acc_inc;
    logic            win_end;
    logic            handshake;

    // -------------------------------------------------------------------------
    // Edge detect and accumulator increment
    // -------------------------------------------------------------------------
    assign rise    = in & ~in_q_reg;

    // One extra bit so the carry out of the accumulator is visible.
    assign acc_sum = {1'b0, acc_reg} + {{CW{1'b0}}, rise};

`ifdef EDGE_WINDOW_SATURATE_EN
    // A carry out means acc was already at all-ones and an edge arrived:
    // hold at the maximum instead of wrapping.
    assign acc_inc = acc_sum[CW] ? {CW{1'b1}} : acc_sum[CW-1:0];
`else
    assign acc_inc = acc_sum[CW-1:0];
`endif

    assign handshake = valid_reg & ready;

    // -------------------------------------------------------------------------
    // Window state machine: next state, window counter, accumulator
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        acc_next   = acc_reg;
        win_end    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // The posedge that starts a run is not a processed cycle,
                // so its edge is intentionally ignored.
                wcnt_next = '0;
                acc_next  = '0;
                if (en) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (!en) begin
                    // Abort: throw away the partial window. A result already
                    // waiting in the output register is left alone.
                    state_next = IDLE;
                    wcnt_next  = '0;
                    acc_next   = '0;
                end else if (wcnt_reg == WLAST) begin
                    // Last cycle of the window: this cycle's edge is part of
                    // the reported total (acc_inc), and the next window
                    // starts immediately on the following posedge.
                    win_end   = 1'b1;
                    wcnt_next = '0;
                    acc_next  = '0;
                end else begin
                    wcnt_next = wcnt_reg + 1'b1;
                    acc_next  = acc_inc;
                end
            end

            default: begin
                state_next = IDLE;
                wcnt_next  = '0;
                acc_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // One-entry output register with sticky drop flag
    // -------------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        valid_next = valid_reg;
        drop_next  = drop_reg;

        if (win_end) begin
            // The slot is free if it was empty or is being emptied at this
            // very edge; otherwise the older result wins.
            if (!valid_reg || handshake) begin
                count_next = acc_inc;
                valid_next = 1'b1;
            end else begin
                drop_next  = 1'b1;
            end
        end else if (handshake) begin
            valid_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            in_q_reg  <= 1'b0;
            wcnt_reg  <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Tracks the input in every state so the first processed cycle
            // after IDLE sees a correct previous value.
            in_q_reg  <= in;
            wcnt_reg  <= wcnt_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            valid_reg <= valid_next;
            drop_reg  <= drop_next;
        end
    end

    assign count = count_reg;
    assign valid = valid_reg;
    assign drop  = drop_reg;

endmodule

// File: tb/tb_edge_window_counter.sv
// -----------------------------------------------------------------------------
// tb_edge_window_counter
//
// Drives two instances from the same stimulus: WINDOW=16/CW=8 (normal) and
// WINDOW=16/CW=2 (overflow). A behavioural model counts edges per window as a
// plain integer and converts to CW bits only when a window is reported. One
// compare process checks both instances against the model every cycle; the
// directed scenarios additionally check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_edge_window_counter;

    localparam int WINDOW = 16;
    localparam int CWA    = 8;
    localparam int CWB    = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           din;
    logic           en;
    logic           ready;
    logic [CWA-1:0] count_a;
    logic           valid_a;
    logic           drop_a;
    logic [CWB-1:0] count_b;
    logic           valid_b;
    logic           drop_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    edge_window_counter #(.WINDOW(WINDOW), .CW(CWA)) dut_a (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .en    (en),
        .ready (ready),
        .count (count_a),
        .valid (valid_a),
        .drop  (drop_a)
    );

    edge_window_counter #(.WINDOW(WINDOW), .CW(CWB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .in    (din),
        .en    (en),
        .ready (ready),
        .count (count_b),
        .valid (valid_b),
        .drop  (drop_b)
    );

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    bit m_running;
    int m_pos;        // processed cycles so far in the current window
    int m_edges;      // unbounded edge count in the current window
    bit m_prev_in;
    bit m_valid;
    bit m_drop;
    int m_count_a;
    int m_count_b;

    function automatic int report(int n, int cw);
        int maxv;
        maxv = (1 << cw) - 1;
`ifdef EDGE_WINDOW_SATURATE_EN
        return (n > maxv) ? maxv : n;
`else
        return n % (1 << cw);
`endif
    endfunction

    always @(posedge clk) begin
        bit e;
        bit hs;
        bit wend;
        int total;
        if (reset) begin
            m_running = 0; m_pos = 0; m_edges = 0; m_prev_in = 0;
            m_valid = 0; m_drop = 0; m_count_a = 0; m_count_b = 0;
        end else begin
            e     = din && !m_prev_in;
            hs    = m_valid && ready;
            wend  = 0;
            total = 0;
            if (!m_running) begin
                m_running = en;
                m_pos = 0; m_edges = 0;
            end else if (!en) begin
                m_running = 0;
                m_pos = 0; m_edges = 0;
            end else begin
                m_edges += int'(e);
                m_pos++;
                if (m_pos == WINDOW) begin
                    wend = 1; total = m_edges;
                    m_pos = 0; m_edges = 0;
                end
            end
            if (wend) begin
                if (!m_valid || hs) begin
                    m_count_a = report(total, CWA);
                    m_count_b = report(total, CWB);
                    m_valid   = 1;
                end else begin
                    m_drop = 1;
                end
            end else if (hs) begin
                m_valid = 0;
            end
            m_prev_in = din;
        end
    end

    // -------------------------------------------------------------------------
    // Per-cycle compare (away from the active edge)
    // -------------------------------------------------------------------------
    task automatic cmp(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("valid_a", int'(valid_a), int'(m_valid));
            cmp("count_a", int'(count_a), m_count_a);
            cmp("drop_a",  int'(drop_a),  int'(m_drop));
            cmp("valid_b", int'(valid_b), int'(m_valid));
            cmp("count_b", int'(count_b), m_count_b);
            cmp("drop_b",  int'(drop_b),  int'(m_drop));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_ticks(int n);
        for (int i = 0; i < n; i++) begin
            din = ~din;
            tick();
        end
    endtask

    int exp_ovf;

    initial begin
`ifdef EDGE_WINDOW_SATURATE_EN
        exp_ovf = 3;
`else
        exp_ovf = 0;
`endif
        reset = 1'b1; din = 1'b0; en = 1'b0; ready = 1'b0;
        tick();
        chk_on = 1'b1;

        // Reset held 3 cycles while in/en toggle.
        for (int i = 0; i < 3; i++) begin
            din = ~din; en = ~en;
            tick();
            cmp("rst_count", int'(count_a), 0);
            cmp("rst_valid", int'(valid_a), 0);
            cmp("rst_drop",  int'(drop_a),  0);
            $display("reset cycle %0d: count=%0d valid=%0d drop=%0d", i, count_a, valid_a, drop_a);
        end
        reset = 1'b0; en = 1'b0;
        tick();
        cmp("post_rst_valid", int'(valid_a), 0);

        // Toggling input, ready=1: first valid after P16, pulse, count 8.
        en = 1'b1; ready = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            din = ~din;
            tick();
            if (i == 16 || i == 18 || i == 32) cmp("tog_valid_low", int'(valid_a), 0);
            if (i == 17 || i == 33) begin
                cmp("tog_valid_hi", int'(valid_a), 1);
                cmp("tog_count", int'(count_a), 8);
                cmp("mdl_count", m_count_a, 8);
                cmp("ovf_count", int'(count_b), exp_ovf);
                $display("toggle window: count_a=%0d count_b=%0d valid=%0d", count_a, count_b, valid_a);
            end
        end

        // Step input: rises at P3 and stays high.
        en = 1'b0; tick(); tick();
        en = 1'b1; din = 1'b0;
        tick(); tick(); tick();          // P0..P2
        din = 1'b1;
        for (int i = 0; i < 14; i++) tick();   // P3..P16
        cmp("step_valid1", int'(valid_a), 1);
        cmp("step_count1", int'(count_a), 1);
        $display("step window 1: count=%0d valid=%0d", count_a, valid_a);
        for (int i = 0; i < 16; i++) tick();
        cmp("step_count2", int'(count_a), 0);
        $display("step window 2: count=%0d valid=%0d", count_a, valid_a);

        // Back-pressure across two window ends.
        en = 1'b0; ready = 1'b1; tick(); tick();
        ready = 1'b0; en = 1'b1;
        toggle_ticks(33);                // P0..P32
        cmp("bp_valid", int'(valid_a), 1);
        cmp("bp_count", int'(count_a), 8);
        cmp("bp_drop",  int'(drop_a),  1);
        $display("backpressure: count=%0d valid=%0d drop=%0d", count_a, valid_a, drop_a);
        ready = 1'b1;
        toggle_ticks(1);                 // P33 handshake
        ready = 1'b0;
        cmp("bp_consumed", int'(valid_a), 0);
        toggle_ticks(15);                // P34..P48
        cmp("bp_reload_valid", int'(valid_a), 1);
        cmp("bp_reload_count", int'(count_a), 8);
        cmp("bp_drop_sticky",  int'(drop_a),  1);
        $display("reload: count=%0d valid=%0d drop=%0d", count_a, valid_a, drop_a);

        // Abort by dropping en after 5 edges.
        reset = 1'b1; tick(); reset = 1'b0;
        ready = 1'b1; en = 1'b1;
        toggle_ticks(11);                // P0..P10
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            toggle_ticks(1);
            cmp("abort_no_valid", int'(valid_a), 0);
        end
        en = 1'b1;
        toggle_ticks(17);
        cmp("abort_rerun_valid", int'(valid_a), 1);
        cmp("abort_rerun_count", int'(count_a), 8);
        $display("after abort: count=%0d valid=%0d", count_a, valid_a);

        // Reset mid-window with a pending result and drop set.
        ready = 1'b0;
        toggle_ticks(21);
        cmp("pre_rst_drop", int'(drop_a), 1);
        reset = 1'b1;
        toggle_ticks(1);
        cmp("midrst_count", int'(count_a), 0);
        cmp("midrst_valid", int'(valid_a), 0);
        cmp("midrst_drop",  int'(drop_a),  0);
        reset = 1'b0; ready = 1'b1;
        toggle_ticks(17);
        cmp("midrst_rerun_count", int'(count_a), 8);
        cmp("midrst_rerun_valid", int'(valid_a), 1);
        $display("after mid-window reset: count=%0d valid=%0d drop=%0d", count_a, valid_a, drop_a);

        // Randomised phase, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            din   = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 99) < 97);
            ready = ($urandom_range(0, 99) < 40);
            reset = ($urandom_range(0, 399) == 0);
            tick();
            if (valid_a && ready)
                $display("cycle %0d: consumed count_a=%0d count_b=%0d", i, count_a, count_b);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
